// File: rtl/pedal_if.sv
// rtl/pedal_if.sv - key, codec-ready, frame-tick and looper/level signals of the pedal controller
interface pedal_if #(
    parameter int N_FX   = 7,
    parameter int LVL_W  = 3,
    parameter int ADDR_W = 20
);
    localparam int SEL_W = (N_FX > 1) ? $clog2(N_FX) : 1;

    logic                    i_i2c_done;
    logic                    i_key_0;
    logic                    i_key_1;
    logic                    i_key_2;
    logic                    i_frame_tick;
    logic [2:0]              o_state;
    logic [SEL_W-1:0]        o_fx_sel;
    logic [N_FX*LVL_W-1:0]   o_fx_level;
    logic                    o_rec_en;
    logic                    o_play_en;
    logic [ADDR_W-1:0]       o_addr;
    logic [ADDR_W:0]         o_loop_len;

    modport master (
        input  i_i2c_done, i_key_0, i_key_1, i_key_2, i_frame_tick,
        output o_state, o_fx_sel, o_fx_level, o_rec_en, o_play_en, o_addr, o_loop_len
    );

    modport slave (
        output i_i2c_done, i_key_0, i_key_1, i_key_2, i_frame_tick,
        input  o_state, o_fx_sel, o_fx_level, o_rec_en, o_play_en, o_addr, o_loop_len
    );
endinterface

// File: rtl/pedal_ctrl.sv
// rtl/pedal_ctrl.sv - pedal mode controller: codec bring-up, effect settings edit and looper
module pedal_ctrl #(
    parameter int N_FX   = 7,
    parameter int LVL_W  = 3,
    parameter int ADDR_W = 20
) (
    input  logic      i_AUD_BCLK,
    input  logic      i_rst_n,
    pedal_if.master   bus
);
    localparam int SEL_W = (N_FX > 1) ? $clog2(N_FX) : 1;
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_FX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_PLAY = 3'd1,
        S_SET  = 3'd2,
        S_RECD = 3'd3,
        S_LOOP = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [2:0]            key_d;
    logic [SEL_W-1:0]      fx_sel, fx_sel_nxt;
    logic [N_FX*LVL_W-1:0] fx_level, fx_level_nxt;
    logic [ADDR_W-1:0]     addr, addr_nxt;
    logic [ADDR_W:0]       loop_len, loop_len_nxt;
    logic                  ovd, ovd_nxt;

    logic [2:0] key_now;
    logic       press_2, press_1, press_0;

    assign key_now = {bus.i_key_2, bus.i_key_1, bus.i_key_0};

    // Rising-edge detection with key_2 > key_1 > key_0 priority; losers are discarded
    assign press_2 = key_now[2] & ~key_d[2];
    assign press_1 = key_now[1] & ~key_d[1] & ~press_2;
    assign press_0 = key_now[0] & ~key_d[0] & ~press_2 & ~press_1;

    // State and datapath registers
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_INIT;
            key_d    <= '0;
            fx_sel   <= '0;
            fx_level <= '0;
            addr     <= '0;
            loop_len <= '0;
            ovd      <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_d    <= key_now;
            fx_sel   <= fx_sel_nxt;
            fx_level <= fx_level_nxt;
            addr     <= addr_nxt;
            loop_len <= loop_len_nxt;
            ovd      <= ovd_nxt;
        end
    end

    // Next-state and next-datapath decode; a mode-changing press always beats a frame tick
    always_comb begin
        state_nxt    = state;
        fx_sel_nxt   = fx_sel;
        fx_level_nxt = fx_level;
        addr_nxt     = addr;
        loop_len_nxt = loop_len;
        ovd_nxt      = ovd;

        case (state)
            S_INIT: begin
                if (bus.i_i2c_done) state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (press_2) begin
                    state_nxt = S_SET;
                end else if (press_1) begin
                    state_nxt    = S_RECD;
                    addr_nxt     = '0;
                    loop_len_nxt = '0;
                end
            end
            S_SET: begin
                if (press_2) begin
                    state_nxt = S_PLAY;
                end else if (press_1) begin
                    fx_sel_nxt = (fx_sel == SEL_LAST) ? '0 : fx_sel + SEL_W'(1);
                end else if (press_0) begin
                    fx_level_nxt[int'(fx_sel)*LVL_W +: LVL_W] =
                        fx_level[int'(fx_sel)*LVL_W +: LVL_W] + LVL_ONE;
                end
            end
            S_RECD: begin
                if (press_2) begin
                    state_nxt    = S_PLAY;
                    addr_nxt     = '0;
                    loop_len_nxt = '0;
                end else if (press_1) begin
                    addr_nxt = '0;
                    if (addr != '0) begin
                        state_nxt    = S_LOOP;
                        loop_len_nxt = {1'b0, addr};
                        ovd_nxt      = 1'b0;
                    end else begin
                        state_nxt = S_PLAY;
                    end
                end else if (bus.i_frame_tick) begin
                    if (addr == ADDR_MAX) begin
                        state_nxt    = S_LOOP;
                        loop_len_nxt = LEN_FULL;
                        addr_nxt     = '0;
                        ovd_nxt      = 1'b0;
                    end else begin
                        addr_nxt = addr + ADDR_ONE;
                    end
                end
            end
            S_LOOP: begin
                if (press_2 || press_1) begin
                    state_nxt    = S_PLAY;
                    loop_len_nxt = '0;
                    ovd_nxt      = 1'b0;
                    addr_nxt     = '0;
                end else begin
                    if (press_0) ovd_nxt = ~ovd;
                    if (bus.i_frame_tick)
                        addr_nxt = ({1'b0, addr} == loop_len - LEN_ONE) ? '0 : addr + ADDR_ONE;
                end
            end
            default: state_nxt = S_INIT;
        endcase

        // Codec lost: drop back to bring-up, clear the looper, keep effect settings
        if (!bus.i_i2c_done && state != S_INIT) begin
            state_nxt    = S_INIT;
            addr_nxt     = '0;
            loop_len_nxt = '0;
            ovd_nxt      = 1'b0;
        end
    end

    // Output decode from registered state and flags
    always_comb begin
        bus.o_state    = state;
        bus.o_fx_sel   = fx_sel;
        bus.o_fx_level = fx_level;
        bus.o_addr     = addr;
        bus.o_loop_len = loop_len;
        bus.o_play_en  = (state == S_LOOP);
        bus.o_rec_en   = (state == S_RECD) || ((state == S_LOOP) && ovd);
    end
endmodule

// File: tb/tb_pedal_ctrl.sv
// tb/tb_pedal_ctrl.sv - directed self-checking bench for pedal_ctrl
module tb_pedal_ctrl;
    localparam int N_FX   = 7;
    localparam int LVL_W  = 3;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    pedal_if #(.N_FX(N_FX), .LVL_W(LVL_W), .ADDR_W(ADDR_W)) pif ();

    pedal_ctrl #(.N_FX(N_FX), .LVL_W(LVL_W), .ADDR_W(ADDR_W)) dut (
        .i_AUD_BCLK (clk),
        .i_rst_n    (rst_n),
        .bus        (pif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle key pulse; k is a mask {key_2,key_1,key_0}; outputs are settled on return
    task automatic press(input logic [2:0] k, input logic tick = 1'b0);
        @(negedge clk);
        pif.i_key_2      = k[2];
        pif.i_key_1      = k[1];
        pif.i_key_0      = k[0];
        pif.i_frame_tick = tick;
        @(negedge clk);
        pif.i_key_2      = 1'b0;
        pif.i_key_1      = 1'b0;
        pif.i_key_0      = 1'b0;
        pif.i_frame_tick = 1'b0;
    endtask

    task automatic tick();
        press(3'b000, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(pif.o_state), 32'd0);
        check({tag, "_sel"},   32'(pif.o_fx_sel), 32'd0);
        check({tag, "_lvl"},   32'(pif.o_fx_level), 32'd0);
        check({tag, "_rec"},   32'(pif.o_rec_en), 32'd0);
        check({tag, "_play"},  32'(pif.o_play_en), 32'd0);
        check({tag, "_addr"},  32'(pif.o_addr), 32'd0);
        check({tag, "_len"},   32'(pif.o_loop_len), 32'd0);
    endtask

    initial begin
        pif.i_i2c_done   = 1'b0;
        pif.i_key_0      = 1'b0;
        pif.i_key_1      = 1'b0;
        pif.i_key_2      = 1'b0;
        pif.i_frame_tick = 1'b0;
        idle(2);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Bring-up: keys ignored until codec is configured
        press(3'b100);
        press(3'b010);
        press(3'b001);
        check("init_hold", 32'(pif.o_state), 32'd0);
        @(negedge clk);
        pif.i_i2c_done = 1'b1;
        @(negedge clk);
        check("init_to_play", 32'(pif.o_state), 32'd1);

        // Settings edit
        press(3'b100);
        check("enter_set", 32'(pif.o_state), 32'd2);
        for (int i = 0; i < 3; i++) press(3'b010);
        check("sel_3", 32'(pif.o_fx_sel), 32'd3);
        for (int i = 0; i < 9; i++) press(3'b001);
        check("lvl_wrap", 32'(pif.o_fx_level), 32'h200);
        for (int i = 0; i < 4; i++) press(3'b010);
        check("sel_wrap", 32'(pif.o_fx_sel), 32'd0);
        press(3'b100);
        check("set_to_play", 32'(pif.o_state), 32'd1);

        // Record five frames then close the loop
        press(3'b010);
        check("recd_state", 32'(pif.o_state), 32'd3);
        check("recd_rec", 32'(pif.o_rec_en), 32'd1);
        check("recd_play", 32'(pif.o_play_en), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("recd_addr5", 32'(pif.o_addr), 32'd5);
        press(3'b010);
        check("loop_state", 32'(pif.o_state), 32'd4);
        check("loop_len5", 32'(pif.o_loop_len), 32'd5);
        check("loop_addr0", 32'(pif.o_addr), 32'd0);
        check("loop_play", 32'(pif.o_play_en), 32'd1);
        check("loop_rec0", 32'(pif.o_rec_en), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("loop_seq%0d", i), 32'(pif.o_addr), 32'(i % 5));
        end

        // Overdub toggle, then simultaneous key_0+key_1 exits
        press(3'b001);
        check("ovd_on", 32'(pif.o_rec_en), 32'd1);
        press(3'b001);
        check("ovd_off", 32'(pif.o_rec_en), 32'd0);
        press(3'b001);
        press(3'b011);
        check("prio_state", 32'(pif.o_state), 32'd1);
        check("prio_len", 32'(pif.o_loop_len), 32'd0);
        check("prio_rec", 32'(pif.o_rec_en), 32'd0);

        // Full buffer auto transition
        press(3'b010);
        for (int i = 0; i < 15; i++) tick();
        check("full_pre_state", 32'(pif.o_state), 32'd3);
        check("full_pre_addr", 32'(pif.o_addr), 32'd15);
        tick();
        check("full_state", 32'(pif.o_state), 32'd4);
        check("full_len", 32'(pif.o_loop_len), 32'd16);
        check("full_addr", 32'(pif.o_addr), 32'd0);

        // Tick and key_0 in the same cycle both act
        press(3'b001, 1'b1);
        check("tick_k0_addr", 32'(pif.o_addr), 32'd1);
        check("tick_k0_rec", 32'(pif.o_rec_en), 32'd1);
        press(3'b010);
        check("loop_exit", 32'(pif.o_state), 32'd1);

        // Record with no tick then stop: back to PLAY with no loop
        press(3'b010);
        press(3'b010);
        check("empty_state", 32'(pif.o_state), 32'd1);
        check("empty_len", 32'(pif.o_loop_len), 32'd0);

        // Held key_1 produces a single transition
        @(negedge clk);
        pif.i_key_1 = 1'b1;
        idle(100);
        check("held_state", 32'(pif.o_state), 32'd3);
        pif.i_key_1 = 1'b0;
        idle(2);
        check("held_after", 32'(pif.o_state), 32'd3);

        // Key_2 press during record discards it
        tick();
        press(3'b100);
        check("k2_discard_state", 32'(pif.o_state), 32'd1);
        check("k2_discard_len", 32'(pif.o_loop_len), 32'd0);

        // Codec loss in LOOP: looper cleared, levels kept
        press(3'b010);
        for (int i = 0; i < 3; i++) tick();
        press(3'b010);
        check("loss_pre_len", 32'(pif.o_loop_len), 32'd3);
        @(negedge clk);
        pif.i_i2c_done = 1'b0;
        @(negedge clk);
        check("loss_state", 32'(pif.o_state), 32'd0);
        check("loss_len", 32'(pif.o_loop_len), 32'd0);
        check("loss_lvl", 32'(pif.o_fx_level), 32'h200);
        pif.i_i2c_done = 1'b1;
        @(negedge clk);
        check("loss_recover", 32'(pif.o_state), 32'd1);

        // Asynchronous reset mid-loop with overdub active
        press(3'b010);
        for (int i = 0; i < 3; i++) tick();
        press(3'b010);
        press(3'b001);
        tick();
        check("pre_rst_rec", 32'(pif.o_rec_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pedal_ctrl.md
# pedal_ctrl

Parametrised top-level mode controller for the guitar-effects pedal. It sequences codec bring-up, normal play, per-effect settings edit, and a looper with record, playback and overdub. It owns the looper SRAM frame address and the packed per-effect level vector consumed by the DSP chain. It sits between the debounced key inputs, the I2C initializer's finish flag, and the AudDSP/SRAM path, all on the audio bit clock.

## Interface
- N_FX, default 7: number of effect slots (gate, comp, dist, EQb, EQt, trem, chor, …); must be 1..16.
- LVL_W, default 3: bits per effect level; level 0 means bypass.
- ADDR_W, default 20: looper frame-address width; capacity is 2^ADDR_W frames.
- i_AUD_BCLK, input, 1: clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_i2c_done, input, 1: level signal from the I2C initializer; codec configured.
- i_key_0, input, 1: debounced, active-high, level; edit/overdub key.
- i_key_1, input, 1: debounced, active-high, level; next-effect/looper key.
- i_key_2, input, 1: debounced, active-high, level; settings-mode key.
- i_frame_tick, input, 1: one-cycle pulse per stereo sample frame (DACLRCK edge, resynchronised).
- o_state, output, 3: current mode. INIT=0, PLAY=1, SET=2, RECD=3, LOOP=4.
- o_fx_sel, output, clog2(N_FX) (min 1): effect slot being edited.
- o_fx_level, output, N_FX*LVL_W: packed levels; slot k occupies bits [k*LVL_W +: LVL_W].
- o_rec_en, output, 1: SRAM write enable for the current frame.
- o_play_en, output, 1: loop playback mix enable.
- o_addr, output, ADDR_W: SRAM frame address for the current frame.
- o_loop_len, output, ADDR_W+1: recorded loop length in frames; 0 means no loop.

## Operation
- Key press = rising edge: key & ~key_d, where key_d is a registered copy (reset 0). A held key produces exactly one press.
- Simultaneous presses: only the highest-priority press acts (key_2 > key_1 > key_0). Lower-priority presses in the same cycle are discarded.
- INIT: all presses ignored. On i_i2c_done=1, go to PLAY.
- PLAY:
  - key_2 → SET.
  - key_1 → RECD; o_addr←0, o_loop_len←0.
  - key_0 ignored.
- SET:
  - key_2 → PLAY.
  - key_1: o_fx_sel←(o_fx_sel==N_FX-1) ? 0 : o_fx_sel+1.
  - key_0: level of the selected slot +1, wrapping from 2^LVL_W-1 to 0.
  - Levels and o_fx_sel are retained across all modes; only reset clears them.
- RECD:
  - o_rec_en=1, o_play_en=0.
  - Each i_frame_tick: o_addr←o_addr+1. The consumer writes at the pre-increment o_addr.
  - key_1 with o_addr>0 → LOOP; o_loop_len←o_addr; o_addr←0.
  - key_1 with o_addr==0 → PLAY.
  - key_2 → PLAY, recording discarded (o_loop_len←0).
  - Full: a tick at o_addr=2^ADDR_W-1 → LOOP automatically; o_loop_len←2^ADDR_W; o_addr←0.
- LOOP:
  - o_play_en=1. o_rec_en = overdub flag (reset 0; cleared on entering LOOP).
  - Each tick: o_addr←(o_addr==o_loop_len-1) ? 0 : o_addr+1.
  - key_0 toggles overdub.
  - key_1 or key_2 → PLAY; o_loop_len←0; overdub←0; o_addr←0.
- If i_i2c_done deasserts in any non-INIT state → INIT. Looper is cleared; levels are kept.
- Reset values: o_state=INIT, o_fx_sel=0, o_fx_level=0, o_rec_en=0, o_play_en=0, o_addr=0, o_loop_len=0.

## Timing
- Fully synchronous to i_AUD_BCLK except the reset. All outputs are registered; o_rec_en and o_play_en are decoded from registered state and flags.
- Key latency: the key goes high before edge N; the press is acted on at edge N; outputs change after edge N.
- A tick in the same cycle as a mode-changing press: the press wins and the tick is dropped. The only exception is the full-buffer auto transition, which is the tick itself.
- A tick in the same cycle as key_0 in LOOP: both act. The address advances, and overdub toggles for the next frame.
- Reset mid-record or mid-loop: immediate asynchronous return to reset values; no SRAM write is in flight because o_rec_en drops asynchronously.

## Test plan
- Bring-up: reset, keys pulsed while i_i2c_done=0 → o_state stays 0. Raise i_i2c_done → o_state=1 one cycle later.
- Settings, with N_FX=7, LVL_W=3:
  - In SET, 3× key_1 → o_fx_sel=3.
  - 9× key_0 → slot 3 level=1 (wrapped); o_fx_level=0x200 (1<<9), other slots 0.
  - 4 more key_1 → o_fx_sel=0 (wrap).
- Record/loop: key_1, 5 ticks, key_1 → o_loop_len=5, o_state=4. Then 12 ticks → o_addr sequence 1,2,3,4,0,1,…, ending at 2.
- Overdub and priority:
  - In LOOP, key_0 → o_rec_en=1; key_0 again → 0.
  - key_0+key_1 in the same cycle → PLAY, o_loop_len=0, o_rec_en=0.
- Full buffer, with ADDR_W=4: record 16 ticks without key → auto LOOP, o_loop_len=16, o_addr=0.
- Edge cases:
  - key_1 then immediately key_1 with no tick → back to PLAY, o_loop_len=0.
  - Held key_1 for 100 cycles → single transition.
  - Async reset mid-LOOP → all outputs at reset values before the next clock.
